// File: rtl/alu_pkg.sv
// Shared ALU control codes, funct constants, mult/div op and sequencer state types.
// Used by the registered ALU control stage and its mult/div sequencer.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_MFHI = 4'b1010;
    localparam logic [3:0] ALU_MFLO = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_MD   = 4'b1110;
    localparam logic [3:0] ALU_ILL  = 4'b1111;

    localparam logic [1:0] AOP_ADD   = 2'b00;
    localparam logic [1:0] AOP_SUB   = 2'b01;
    localparam logic [1:0] AOP_RTYPE = 2'b10;
    localparam logic [1:0] AOP_OR    = 2'b11;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;

    localparam int MD_CNT_W = 8;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } md_state_e;

endpackage

// File: rtl/md_sequencer.sv
// Mult/div sequencer: start pulse on accept, fixed MD_CYCLES latency, one-cycle done pulse.
// Latency: busy from the accept edge, done MD_CYCLES cycles later; stalls do not extend it.
module md_sequencer
    import alu_pkg::*;
#(
    parameter int MD_CYCLES = 32
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   md_accept,
    input  md_op_e md_op_in,
    output logic   in_busy,
    output logic   md_start,
    output md_op_e md_op,
    output logic   md_busy,
    output logic   md_done
);

    localparam logic [MD_CNT_W-1:0] CNT_LOAD = MD_CNT_W'(MD_CYCLES - 1);

    md_state_e           state_q, state_d;
    logic [MD_CNT_W-1:0] cnt_q, cnt_d;
    logic                start_q, start_d;
    md_op_e              op_q, op_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
            op_q    <= MD_MULT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            op_q    <= op_d;
        end
    end

    // An accept is only possible outside BUSY; the top hazards MD/MF while BUSY.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        op_d    = op_q;
        case (state_q)
            IDLE, DONE: begin
                if (md_accept) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                    start_d = 1'b1;
                    op_d    = md_op_in;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - MD_CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_busy  = (state_q == BUSY);
        md_busy  = (state_q != IDLE);
        md_done  = (state_q == DONE);
        md_start = start_q;
        md_op    = op_q;
    end

endmodule

// File: rtl/alu_control_seq.sv
// Registered ALU control decode (1-cycle latency) plus mult/div sequencer.
// Backpressure: iStall_wire freezes decode outputs; oHazard_wire stalls MD/MF while the unit is busy.
module alu_control_seq
    import alu_pkg::*;
#(
    parameter int FUNCT_W   = 6,
    parameter int ALUOP_W   = 2,
    parameter int CTL_W     = 4,
    parameter int MD_CYCLES = 32
) (
    input  logic               iClk_wire,
    input  logic               iReset_wire,
    input  logic               iValid_wire,
    input  logic               iStall_wire,
    input  logic [ALUOP_W-1:0] iAluop_wire,
    input  logic [FUNCT_W-1:0] iFunct_wire,
    output logic [CTL_W-1:0]   oAluctl_reg,
    output logic               oValid_reg,
    output logic               oIllegal_reg,
    output logic               oMdStart_reg,
    output logic [1:0]         oMdOp_reg,
    output logic               oMdBusy_reg,
    output logic               oMdDone_reg,
    output logic               oHazard_wire
);

    logic [3:0]       dec_ctl;
    logic             dec_ill;
    logic             is_md;
    logic             is_mf;
    logic             accept;
    logic             seq_in_busy;
    md_op_e           seq_op;

    logic [CTL_W-1:0] aluctl_q, aluctl_d;
    logic             valid_q, valid_d;
    logic             illegal_q, illegal_d;

    always_comb begin
        dec_ctl = ALU_ILL;
        dec_ill = 1'b0;
        is_md   = 1'b0;
        is_mf   = 1'b0;
        case (iAluop_wire)
            ALUOP_W'(AOP_ADD): dec_ctl = ALU_ADD;
            ALUOP_W'(AOP_SUB): dec_ctl = ALU_SUB;
            ALUOP_W'(AOP_OR):  dec_ctl = ALU_OR;
            ALUOP_W'(AOP_RTYPE): begin
                case (iFunct_wire)
                    FUNCT_W'(F_ADD), FUNCT_W'(F_ADDU): dec_ctl = ALU_ADD;
                    FUNCT_W'(F_SUB), FUNCT_W'(F_SUBU): dec_ctl = ALU_SUB;
                    FUNCT_W'(F_AND):  dec_ctl = ALU_AND;
                    FUNCT_W'(F_OR):   dec_ctl = ALU_OR;
                    FUNCT_W'(F_NOR):  dec_ctl = ALU_NOR;
                    FUNCT_W'(F_SLT):  dec_ctl = ALU_SLT;
                    FUNCT_W'(F_SLL):  dec_ctl = ALU_SLL;
                    FUNCT_W'(F_SRL):  dec_ctl = ALU_SRL;
                    FUNCT_W'(F_MFHI): begin dec_ctl = ALU_MFHI; is_mf = 1'b1; end
                    FUNCT_W'(F_MFLO): begin dec_ctl = ALU_MFLO; is_mf = 1'b1; end
                    FUNCT_W'(F_MULT), FUNCT_W'(F_MULTU),
                    FUNCT_W'(F_DIV),  FUNCT_W'(F_DIVU): begin
                        dec_ctl = ALU_MD;
                        is_md   = 1'b1;
                    end
                    default: begin dec_ctl = ALU_ILL; dec_ill = 1'b1; end
                endcase
            end
            default: dec_ctl = ALU_ILL;
        endcase
    end

    always_comb begin
        oHazard_wire = iValid_wire & (is_md | is_mf) & seq_in_busy;
        accept       = iValid_wire & ~iStall_wire & ~oHazard_wire;
    end

    // A bubble clears only valid; the rest of the decode stays as last loaded.
    always_comb begin
        aluctl_d  = aluctl_q;
        valid_d   = valid_q;
        illegal_d = illegal_q;
        if (accept) begin
            aluctl_d  = CTL_W'(dec_ctl);
            valid_d   = 1'b1;
            illegal_d = dec_ill;
        end else if (!iStall_wire) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge iClk_wire) begin
        if (iReset_wire) begin
            aluctl_q  <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            aluctl_q  <= aluctl_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
        end
    end

    md_sequencer #(
        .MD_CYCLES (MD_CYCLES)
    ) u_md_sequencer (
        .clk       (iClk_wire),
        .rst       (iReset_wire),
        .md_accept (accept & is_md),
        .md_op_in  (md_op_e'(iFunct_wire[1:0])),
        .in_busy   (seq_in_busy),
        .md_start  (oMdStart_reg),
        .md_op     (seq_op),
        .md_busy   (oMdBusy_reg),
        .md_done   (oMdDone_reg)
    );

    assign oAluctl_reg  = aluctl_q;
    assign oValid_reg   = valid_q;
    assign oIllegal_reg = illegal_q;
    assign oMdOp_reg    = seq_op;

endmodule
